// File: rtl/sort_engine.sv
// In-place selection sorter over K N-bit entries with host load/read ports.
// Define SORT_SIGNED_EN to compare entries as two's-complement signed values.
module sort_engine #(
    parameter int N  = 8,
    parameter int K  = 10,
    localparam int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          start,
    input  logic          desc,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] swap_cnt,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);

    localparam logic [AW-1:0] LAST = AW'(K - 1);
    localparam logic [AW-1:0] PEN  = AW'(K - 2);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_SCAN, S_SWAP, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mem_q [K];
    logic [N-1:0]  mem_d [K];
    logic [AW-1:0] i_q, i_d, j_q, j_d, sel_q, sel_d, swap_q, swap_d;
    logic [N-1:0]  a_q, a_d, rd_q;
    logic          desc_q, desc_d;

    // Strict compare: true when x should displace the current pick y.
    function automatic logic better(input logic [N-1:0] x, input logic [N-1:0] y,
                                    input logic d);
        logic lt, gt;
`ifdef SORT_SIGNED_EN
        lt = $signed(x) < $signed(y);
        gt = $signed(x) > $signed(y);
`else
        lt = x < y;
        gt = x > y;
`endif
        return d ? gt : lt;
    endfunction

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        i_d     = i_q;
        j_d     = j_q;
        sel_d   = sel_q;
        a_d     = a_q;
        desc_d  = desc_q;
        swap_d  = swap_q;
        case (state_q)
            S_IDLE: begin
                if (wr_en && wr_addr <= LAST) mem_d[wr_addr] = wr_data;
                if (start) begin
                    desc_d  = desc;
                    i_d     = '0;
                    swap_d  = '0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                a_d     = mem_q[i_q];
                sel_d   = i_q;
                j_d     = i_q + AW'(1);
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (better(mem_q[j_q], a_q, desc_q)) begin
                    a_d   = mem_q[j_q];
                    sel_d = j_q;
                end
                if (j_q == LAST) state_d = S_SWAP;
                else             j_d = j_q + AW'(1);
            end
            S_SWAP: begin
                // a_q still equals mem_q[sel_q]: the array is untouched during a scan.
                if (sel_q != i_q) begin
                    mem_d[sel_q] = mem_q[i_q];
                    mem_d[i_q]   = a_q;
                    swap_d       = swap_q + AW'(1);
                end
                if (i_q == PEN) state_d = S_FIN;
                else begin
                    i_d     = i_q + AW'(1);
                    state_d = S_INIT;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int k = 0; k < K; k++) mem_q[k] <= '0;
            i_q     <= '0;
            j_q     <= '0;
            sel_q   <= '0;
            a_q     <= '0;
            desc_q  <= 1'b0;
            swap_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            i_q     <= i_d;
            j_q     <= j_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            desc_q  <= desc_d;
            swap_q  <= swap_d;
            rd_q    <= (rd_addr <= LAST) ? mem_q[rd_addr] : '0;
        end
    end

    assign busy     = (state_q == S_INIT) || (state_q == S_SCAN) || (state_q == S_SWAP);
    assign done     = (state_q == S_FIN);
    assign swap_cnt = swap_q;
    assign rd_data  = rd_q;

endmodule

// File: tb/tb_sort_engine.sv
// Randomised self-checking bench for sort_engine against a behavioural selection-sort model.
module tb_sort_engine;

    localparam int N   = 8;
    localparam int K   = 10;
    localparam int AW  = $clog2(K);
    localparam int LAT = (K - 1) * (K + 1) - (K - 1) * (K - 2) / 2;

    logic          clk = 1'b0;
    logic          rst, wr_en, start, desc;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [N-1:0]  wr_data;
    logic          busy, done;
    logic [AW-1:0] swap_cnt;
    logic [N-1:0]  rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] mdl [K];
    logic [N-1:0] rb  [K];
    logic [N-1:0] tv  [K];
    logic [N-1:0] ev  [K];
    int           mdl_sw;
    int           lat, ndone;

    sort_engine #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .desc(desc), .busy(busy), .done(done), .swap_cnt(swap_cnt),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit prefer(logic [N-1:0] x, logic [N-1:0] y, bit d);
`ifdef SORT_SIGNED_EN
        int sx, sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
`else
        int sx, sy;
        sx = int'(x);
        sy = int'(y);
`endif
        return d ? (sx > sy) : (sx < sy);
    endfunction

    // Selection sort by its textbook definition: pick the first extreme, swap if elsewhere.
    task automatic model_sort(input bit d);
        logic [N-1:0] t;
        int best;
        mdl_sw = 0;
        for (int i = 0; i < K - 1; i++) begin
            best = i;
            for (int j = i + 1; j < K; j++)
                if (prefer(mdl[j], mdl[best], d)) best = j;
            if (best != i) begin
                t = mdl[i]; mdl[i] = mdl[best]; mdl[best] = t;
                mdl_sw++;
            end
        end
    endtask

    task automatic load_mdl();
        for (int k = 0; k < K; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = mdl[k];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_all();
        for (int k = 0; k < K; k++) begin
            rd_addr = AW'(k);
            tick();
            rb[k] = rd_data;
        end
    endtask

    // Starts a sort and counts busy cycles; abuse pokes start/writes while busy.
    task automatic run_sort(input bit d, input bit abuse);
        start = 1'b1; desc = d;
        tick();
        start = 1'b0; wr_en = 1'b0; desc = 1'($urandom_range(0, 1));
        lat = 0; ndone = 0;
        while (busy === 1'b1 && lat < 1000) begin
            lat++;
            if (done === 1'b1) ndone++;
            if (abuse && lat == 5) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = '1;
            end else if (abuse && lat == 6) begin
                start = 1'b0; wr_addr = AW'(12); wr_data = 8'h5A;
            end else if (abuse && lat == 7) begin
                wr_en = 1'b0;
            end
            tick();
        end
        if (done === 1'b1) ndone++;
        tick();
        if (done === 1'b1) ndone++;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (swap_cnt !== '0) begin n_bad++; $display("FAIL reset_swap got %0d want 0", swap_cnt); end
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL reset_rd got %0h want 0", rd_data); end
        rst = 1'b0;
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== '0) begin n_bad++; $display("FAIL reset_mem[%0d] got %0h want 0", k, rb[k]); end
        end
    endtask

    task automatic test_ascending();
        tv = '{8'h42, 8'h12, 8'h02, 8'h20, 8'h2a, 8'h29, 8'h22, 8'h52, 8'h01, 8'h00};
        ev = '{8'h00, 8'h01, 8'h02, 8'h12, 8'h20, 8'h22, 8'h29, 8'h2a, 8'h42, 8'h52};
        mdl = tv; load_mdl(); model_sort(1'b0);
        run_sort(1'b0, 1'b0);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL asc_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL asc_done_pulses got %0d want 1", ndone); end
        n_cmp++; if (swap_cnt !== AW'(7)) begin n_bad++; $display("FAIL asc_swap got %0d want 7", swap_cnt); end
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== ev[k] || rb[k] !== mdl[k])
                begin n_bad++; $display("FAIL asc_data[%0d] got %0h want %0h", k, rb[k], ev[k]); end
        end
    endtask

    task automatic test_descending();
        tv = '{8'h42, 8'h12, 8'h02, 8'h20, 8'h2a, 8'h29, 8'h22, 8'h52, 8'h01, 8'h00};
        ev = '{8'h52, 8'h42, 8'h2a, 8'h29, 8'h22, 8'h20, 8'h12, 8'h02, 8'h01, 8'h00};
        mdl = tv; load_mdl(); model_sort(1'b1);
        run_sort(1'b1, 1'b0);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL desc_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (swap_cnt !== AW'(mdl_sw)) begin n_bad++; $display("FAIL desc_swap got %0d want %0d", swap_cnt, mdl_sw); end
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== ev[k]) begin n_bad++; $display("FAIL desc_data[%0d] got %0h want %0h", k, rb[k], ev[k]); end
        end
    endtask

    task automatic test_presorted();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < K; k++) tv[k] = (pass == 0) ? N'(k) : N'(8'h33);
            mdl = tv; load_mdl();
            run_sort(1'b0, 1'b0);
            n_cmp++; if (swap_cnt !== '0) begin n_bad++; $display("FAIL presort%0d_swap got %0d want 0", pass, swap_cnt); end
            n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL presort%0d_latency got %0d want %0d", pass, lat, LAT); end
            read_all();
            for (int k = 0; k < K; k++) begin
                n_cmp++;
                if (rb[k] !== tv[k]) begin n_bad++; $display("FAIL presort%0d_data[%0d] got %0h want %0h", pass, k, rb[k], tv[k]); end
            end
        end
    endtask

    task automatic test_random();
        bit d;
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < K; k++)
                mdl[k] = N'((it % 2) ? $urandom_range(0, 7) : $urandom_range(0, 255));
            d = 1'($urandom_range(0, 1));
            load_mdl(); model_sort(d);
            run_sort(d, 1'b0);
            n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, LAT); end
            n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL rand%0d_done got %0d want 1", it, ndone); end
            n_cmp++; if (swap_cnt !== AW'(mdl_sw)) begin n_bad++; $display("FAIL rand%0d_swap got %0d want %0d", it, swap_cnt, mdl_sw); end
            read_all();
            for (int k = 0; k < K; k++) begin
                n_cmp++;
                if (rb[k] !== mdl[k]) begin n_bad++; $display("FAIL rand%0d_data[%0d] got %0h want %0h", it, k, rb[k], mdl[k]); end
            end
        end
    endtask

    task automatic test_write_with_start();
        for (int k = 0; k < K; k++) mdl[k] = N'($urandom_range(0, 255));
        load_mdl();
        mdl[3] = 8'hC7;
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'hC7;
        model_sort(1'b0);
        run_sort(1'b0, 1'b0);
        n_cmp++; if (swap_cnt !== AW'(mdl_sw)) begin n_bad++; $display("FAIL wrstart_swap got %0d want %0d", swap_cnt, mdl_sw); end
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== mdl[k]) begin n_bad++; $display("FAIL wrstart_data[%0d] got %0h want %0h", k, rb[k], mdl[k]); end
        end
    endtask

    task automatic test_abuse();
        for (int k = 0; k < K; k++) mdl[k] = N'($urandom_range(0, 200));
        load_mdl(); model_sort(1'b1);
        run_sort(1'b1, 1'b1);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL abuse_latency got %0d want %0d", lat, LAT); end
        n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL abuse_done got %0d want 1", ndone); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abuse_restart busy=%0b want 0", busy); end
        n_cmp++; if (swap_cnt !== AW'(mdl_sw)) begin n_bad++; $display("FAIL abuse_swap got %0d want %0d", swap_cnt, mdl_sw); end
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== mdl[k]) begin n_bad++; $display("FAIL abuse_data[%0d] got %0h want %0h", k, rb[k], mdl[k]); end
        end
        wr_en = 1'b1; wr_addr = AW'(12); wr_data = 8'hEE; tick(); wr_en = 1'b0;
        rd_addr = AW'(12); tick();
        n_cmp++; if (rd_data !== '0) begin n_bad++; $display("FAIL abuse_oob_read got %0h want 0", rd_data); end
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== mdl[k]) begin n_bad++; $display("FAIL abuse_oob_write[%0d] got %0h want %0h", k, rb[k], mdl[k]); end
        end
    endtask

    task automatic test_reset_mid_sort();
        int c;
        for (int k = 0; k < K; k++) mdl[k] = N'($urandom_range(1, 255));
        load_mdl();
        start = 1'b1; desc = 1'b0; tick(); start = 1'b0;
        c = 1;
        while (c < 20 && busy === 1'b1) begin c++; tick(); end
        rst = 1'b1; tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %0b want 0", done); end
        n_cmp++; if (swap_cnt !== '0) begin n_bad++; $display("FAIL midrst_swap got %0d want 0", swap_cnt); end
        rst = 1'b0;
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== '0) begin n_bad++; $display("FAIL midrst_clear[%0d] got %0h want 0", k, rb[k]); end
        end
        for (int k = 0; k < K; k++) mdl[k] = N'($urandom_range(0, 255));
        load_mdl(); model_sort(1'b0);
        run_sort(1'b0, 1'b0);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL midrst_resort_latency got %0d want %0d", lat, LAT); end
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== mdl[k]) begin n_bad++; $display("FAIL midrst_resort[%0d] got %0h want %0h", k, rb[k], mdl[k]); end
        end
    endtask

    task automatic test_signed();
        tv = '{8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
`ifdef SORT_SIGNED_EN
        ev = '{8'h80, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h7F};
`else
        ev = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h7F, 8'h80, 8'hFF};
`endif
        mdl = tv; load_mdl();
        run_sort(1'b0, 1'b0);
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL sign_latency got %0d want %0d", lat, LAT); end
        read_all();
        for (int k = 0; k < K; k++) begin
            n_cmp++;
            if (rb[k] !== ev[k]) begin n_bad++; $display("FAIL sign_data[%0d] got %0h want %0h", k, rb[k], ev[k]); end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; start = 1'b0; desc = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        test_reset();
        test_ascending();
        test_descending();
        test_presorted();
        test_random();
        test_write_with_start();
        test_abuse();
        test_reset_mid_sort();
        test_signed();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
